vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_timeout_timer.sv | 30 +++
 rtl/vend_controller.sv | 165 ++++++++++++++++
 tb/tb_vend_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// accepted coin denominations, default prices and timeout.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [4:0] COIN_1  = 5'd1;
  localparam logic [4:0] COIN_2  = 5'd2;
  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;

  localparam int DEFAULT_TIMEOUT = 100;
  localparam int DEFAULT_PRICE_1 = 5;
  localparam int DEFAULT_PRICE_2 = 10;
  localparam int DEFAULT_PRICE_3 = 15;

  localparam int CREDIT_MAX = 31;

  function automatic logic coin_ok(input logic [4:0] value);
    return (value == COIN_1) || (value == COIN_2) ||
           (value == COIN_5) || (value == COIN_10);
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle-cycle counter for the COLLECT state; expired is high once the count
// has reached TIMEOUT_CYCLES-1 and stays there until cleared.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register in the
  // design samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: collects credit, vends on selection,
// refunds on cancel or inactivity. All outputs are registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int PRICE_1        = DEFAULT_PRICE_1,
  parameter int PRICE_2        = DEFAULT_PRICE_2,
  parameter int PRICE_3        = DEFAULT_PRICE_3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] product_sel,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       price_low,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic       change_valid,
  output logic [4:0] change_amount,
  output logic       busy
);

  state_t     state, next_state;
  logic [4:0] credit_d;
  logic       coin_reject_d, price_low_d, dispense_d, change_valid_d, busy_d;
  logic [1:0] dispense_id_d;
  logic [4:0] change_amount_d;
  logic       timer_clear, timer_expired;
  logic [5:0] coin_sum;
  logic [4:0] price;
  logic       coin_fits;

  vend_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (state == COLLECT),
    .expired(timer_expired)
  );

  // Sum is one bit wider so an overflowing coin is detected, never wrapped.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits = coin_ok(coin_value) && (coin_sum <= 6'(CREDIT_MAX));

  always_comb begin
    case (product_sel)
      2'b01:   price = 5'(PRICE_1);
      2'b10:   price = 5'(PRICE_2);
      2'b11:   price = 5'(PRICE_3);
      default: price = 5'd0;
    endcase
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state      = state;
    credit_d        = credit;
    coin_reject_d   = 1'b0;
    price_low_d     = 1'b0;
    dispense_d      = 1'b0;
    dispense_id_d   = 2'b00;
    change_valid_d  = 1'b0;
    change_amount_d = 5'd0;
    timer_clear     = 1'b1;

    case (state)
      IDLE: begin
        if (coin_valid) begin
          if (coin_ok(coin_value)) begin
            credit_d   = coin_value;
            next_state = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (cancel) begin
          coin_reject_d   = coin_valid;
          change_valid_d  = 1'b1;
          change_amount_d = credit;
          credit_d        = 5'd0;
          next_state      = CHANGE;
        end else if (sel_valid && product_sel != 2'b00) begin
          coin_reject_d = coin_valid;
          if (credit >= price) begin
            dispense_d    = 1'b1;
            dispense_id_d = product_sel;
            credit_d      = credit - price;
            next_state    = DISPENSE;
          end else begin
            price_low_d = 1'b1;
          end
        end else if (coin_valid && coin_fits) begin
          credit_d = coin_sum[4:0];
        end else begin
          coin_reject_d = coin_valid;
          if (timer_expired) begin
            change_valid_d  = 1'b1;
            change_amount_d = credit;
            credit_d        = 5'd0;
            next_state      = CHANGE;
          end else begin
            timer_clear = 1'b0;
          end
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (credit != 5'd0) begin
          change_valid_d  = 1'b1;
          change_amount_d = credit;
          credit_d        = 5'd0;
          next_state      = CHANGE;
        end else begin
          next_state = IDLE;
        end
      end

      CHANGE: begin
        coin_reject_d = coin_valid;
        next_state    = IDLE;
      end

      default: next_state = IDLE;
    endcase

    busy_d = (next_state == DISPENSE) || (next_state == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      credit        <= 5'd0;
      coin_reject   <= 1'b0;
      price_low     <= 1'b0;
      dispense      <= 1'b0;
      dispense_id   <= 2'b00;
      change_valid  <= 1'b0;
      change_amount <= 5'd0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      credit        <= credit_d;
      coin_reject   <= coin_reject_d;
      price_low     <= price_low_d;
      dispense      <= dispense_d;
      dispense_id   <= dispense_id_d;
      change_valid  <= change_valid_d;
      change_amount <= change_amount_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: stimulus pushes expected output events
// into a queue, a negedge monitor pops and compares them as they appear.
module tb_vend_controller;
  import vend_pkg::*;

  localparam int TC = 100;

  localparam logic [1:0] EV_REJ  = 2'd0;
  localparam logic [1:0] EV_LOW  = 2'd1;
  localparam logic [1:0] EV_DISP = 2'd2;
  localparam logic [1:0] EV_CHG  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [4:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       sel_valid;
  logic [1:0] product_sel;
  logic       cancel;
  logic [4:0] credit;
  logic       coin_reject;
  logic       price_low;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [4:0] change_amount;
  logic       busy;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  vend_controller #(
    .TIMEOUT_CYCLES(TC),
    .PRICE_1       (5),
    .PRICE_2       (10),
    .PRICE_3       (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .product_sel  (product_sel),
    .cancel       (cancel),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .price_low    (price_low),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [4:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [4:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %0d expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_value", 32'(val), 32'(e.val));
    end
  endtask

  // Within one cycle events are observed in a fixed order: reject, low, dispense, change.
  always @(negedge clk) begin
    if (coin_reject)  observe(EV_REJ, 5'd0);
    if (price_low)    observe(EV_LOW, 5'd0);
    if (dispense)     observe(EV_DISP, {3'b000, dispense_id});
    if (change_valid) observe(EV_CHG, change_amount);
  end

  // One-cycle stimulus, launched and retired on negedges.
  task automatic drive(input logic cv, input logic [4:0] val, input logic sv,
                       input logic [1:0] sel, input logic cn);
    coin_valid  = cv;
    coin_value  = val;
    sel_valid   = sv;
    product_sel = sel;
    cancel      = cn;
    @(negedge clk);
    coin_valid  = 1'b0;
    coin_value  = 5'd0;
    sel_valid   = 1'b0;
    product_sel = 2'b00;
    cancel      = 1'b0;
  endtask

  task automatic coin(input logic [4:0] v);
    drive(1'b1, v, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic select(input logic [1:0] s);
    drive(1'b0, 5'd0, 1'b1, s, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    coin_valid = 1'b0; coin_value = 5'd0;
    sel_valid = 1'b0; product_sel = 2'b00; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_credit", 32'(credit), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_pulses", 32'({coin_reject, price_low, dispense, change_valid}), 0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    // Invalid coin in IDLE, then cancel in IDLE is ignored.
    expect_ev(EV_REJ, 5'd0);
    coin(5'd3);
    check("bad_coin_credit", 32'(credit), 0);
    check("bad_coin_state", 32'(dut.state), 32'(IDLE));
    drive(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    check("idle_cancel_state", 32'(dut.state), 32'(IDLE));

    // 5 + 10, buy product 10 for 10, change 5.
    coin(5'd5);
    check("credit_5", 32'(credit), 5);
    coin(5'd10);
    check("credit_15", 32'(credit), 15);
    expect_ev(EV_DISP, 5'd2);
    expect_ev(EV_CHG, 5'd5);
    select(2'b10);
    check("dispense_busy", 32'(busy), 1);
    check("dispense_credit", 32'(credit), 5);
    idle(1);
    check("change_credit", 32'(credit), 0);
    check("change_busy", 32'(busy), 1);
    idle(1);
    check("after_vend_busy", 32'(busy), 0);
    check("after_vend_state", 32'(dut.state), 32'(IDLE));

    // Price too low, then cancel refunds.
    coin(5'd5);
    expect_ev(EV_LOW, 5'd0);
    select(2'b11);
    check("price_low_credit", 32'(credit), 5);
    check("price_low_state", 32'(dut.state), 32'(COLLECT));
    expect_ev(EV_CHG, 5'd5);
    drive(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    idle(2);

    // Overflow: 30 + 2 rejected; sel 00 ignored; buy 15, change 15.
    coin(5'd10);
    coin(5'd10);
    coin(5'd10);
    expect_ev(EV_REJ, 5'd0);
    coin(5'd2);
    check("overflow_credit", 32'(credit), 30);
    select(2'b00);
    check("sel_none_credit", 32'(credit), 30);
    expect_ev(EV_DISP, 5'd3);
    expect_ev(EV_CHG, 5'd15);
    select(2'b11);
    idle(2);

    // cancel + sel + coin in one cycle: refund wins, coin rejected.
    coin(5'd10);
    expect_ev(EV_REJ, 5'd0);
    expect_ev(EV_CHG, 5'd10);
    drive(1'b1, 5'd5, 1'b1, 2'b01, 1'b1);
    check("priority_credit", 32'(credit), 0);
    idle(2);

    // Coin during DISPENSE is rejected, change still paid.
    coin(5'd10);
    expect_ev(EV_DISP, 5'd1);
    select(2'b01);
    expect_ev(EV_REJ, 5'd0);
    expect_ev(EV_CHG, 5'd5);
    coin(5'd5);
    idle(2);

    // Timeout refund lands exactly TC cycles after the coin edge.
    coin(5'd1);
    expect_ev(EV_CHG, 5'd1);
    k = 0;
    while (k < TC + 10) begin
      @(negedge clk);
      k++;
      if (change_valid) break;
    end
    check("timeout_cycles", 32'(k), 32'(TC));
    idle(2);

    // Reset during DISPENSE discards the remainder.
    coin(5'd10);
    expect_ev(EV_DISP, 5'd1);
    select(2'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", 32'({credit, coin_reject, price_low, dispense, dispense_id,
                               change_valid, change_amount, busy}), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
